enc_pend_rr: RTL and testbench

Parametrised N-input request encoder with sticky pending bits, per-bit masking, selectable fixed-priority or round-robin selection, and a registered index output on a valid/ready handshake. It is the sequential, handshaked successor to the team's combinational 8:3 encoder. It sits between interrupt/event sources and a single consumer that services one index at a time.

---
 rtl/enc_pend_rr_pkg.sv | 13 +
 rtl/enc_pick.sv | 45 ++++
 rtl/enc_pend_rr.sv | 108 ++++++++++
 tb/tb_enc_pend_rr.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pend_rr_pkg.sv
// Shared definitions for the pending-request encoder: selection modes and
// the two-state output FSM encoding.
package enc_pend_rr_pkg;

    localparam logic ENC_MODE_FIXED = 1'b0;
    localparam logic ENC_MODE_RR    = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_t;

endpackage

// File: rtl/enc_pick.sv
// Combinational selector: picks one set bit of vector either by fixed
// priority (highest index wins) or round-robin starting just after ptr.
// Also reports whether any bit is set and whether two or more are set.
module enc_pick
    import enc_pend_rr_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vector,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         multi
);

    logic [2*N-1:0] doubled;

    assign doubled = {vector, vector};

    // Select an index; the round-robin search walks the doubled vector from
    // ptr+1 up to ptr+N so wrap-around needs no modulo hardware.
    always_comb begin
        idx = '0;
        if (mode == ENC_MODE_FIXED) begin
            for (int i = 0; i < N; i++) begin
                if (vector[i]) idx = W'(i);
            end
        end else begin
            for (int p = 2*N-1; p >= 0; p--) begin
                if (doubled[p] && (p > int'(ptr)) && (p <= int'(ptr) + N)) begin
                    idx = W'((p >= N) ? (p - N) : p);
                end
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb begin
        any   = |vector;
        multi = |(vector & (vector - {{(N-1){1'b0}}, 1'b1}));
    end

endmodule

// File: rtl/enc_pend_rr.sv
// N-input request encoder with sticky pending bits, per-bit masking and a
// registered index output on a valid/ready handshake.
module enc_pend_rr
    import enc_pend_rr_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int RR = 0,
    localparam int W  = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic         out_multi,
    output logic [N-1:0] pend
);

    localparam logic PICK_MODE = (RR != 0) ? ENC_MODE_RR : ENC_MODE_FIXED;

    enc_state_t   state_q, state_d;
    logic [N-1:0] pend_q;
    logic [W-1:0] idx_q;
    logic         multi_q;
    logic [W-1:0] ptr_q;

    logic         accept;
    logic [N-1:0] clr;
    logic [N-1:0] elig;
    logic [W-1:0] pick_ptr;
    logic [W-1:0] pick_idx;
    logic         pick_any;
    logic         pick_multi;
    logic         load;

    assign accept   = (state_q == HOLD) && out_ready;
    assign elig     = pend_q & ~mask & ~clr;
    assign pick_ptr = accept ? idx_q : ptr_q;

    // One-hot clear of the index being handed over this cycle.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++) begin
            clr[i] = accept && (idx_q == W'(i));
        end
    end

    enc_pick #(.N(N)) u_pick (
        .vector (elig),
        .ptr    (pick_ptr),
        .mode   (PICK_MODE),
        .idx    (pick_idx),
        .any    (pick_any),
        .multi  (pick_multi)
    );

    // State register for the output FSM.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and load decision: load from IDLE or straight after a handshake.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    if (pick_any) load = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending bits, output registers and round-robin pointer; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            idx_q   <= '0;
            multi_q <= 1'b0;
            ptr_q   <= W'(N-1);
        end else begin
            pend_q <= (pend_q & ~clr) | req;
            if (load) begin
                idx_q   <= pick_idx;
                multi_q <= pick_multi;
            end
            if (accept) ptr_q <= idx_q;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_idx   = idx_q;
    assign out_multi = multi_q;
    assign pend      = pend_q;

endmodule

// File: tb/tb_enc_pend_rr.sv
// Directed bench for enc_pend_rr: fixed-priority N=8, round-robin N=8 and
// round-robin N=5 instances share one clock and reset.
module tb_enc_pend_rr;

    logic       clk;
    logic       rst;

    logic [7:0] a_req, a_mask;
    logic       a_rdy, a_valid, a_multi;
    logic [2:0] a_idx;
    logic [7:0] a_pend;

    logic [7:0] b_req, b_mask;
    logic       b_rdy, b_valid, b_multi;
    logic [2:0] b_idx;
    logic [7:0] b_pend;

    logic [4:0] c_req, c_mask;
    logic       c_rdy, c_valid, c_multi;
    logic [2:0] c_idx;
    logic [4:0] c_pend;

    int errors;
    int checks;

    enc_pend_rr #(.N(8), .RR(0)) dut_a (
        .clk(clk), .rst(rst), .req(a_req), .mask(a_mask), .out_ready(a_rdy),
        .out_valid(a_valid), .out_idx(a_idx), .out_multi(a_multi), .pend(a_pend)
    );

    enc_pend_rr #(.N(8), .RR(1)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .mask(b_mask), .out_ready(b_rdy),
        .out_valid(b_valid), .out_idx(b_idx), .out_multi(b_multi), .pend(b_pend)
    );

    enc_pend_rr #(.N(5), .RR(1)) dut_c (
        .clk(clk), .rst(rst), .req(c_req), .mask(c_mask), .out_ready(c_rdy),
        .out_valid(c_valid), .out_idx(c_idx), .out_multi(c_multi), .pend(c_pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input int sel, input logic [7:0] r,
                                 input logic [7:0] m, input logic rdy);
        case (sel)
            0: begin a_req = r; a_mask = m; a_rdy = rdy; end
            1: begin b_req = r; b_mask = m; b_rdy = rdy; end
            default: begin c_req = r[4:0]; c_mask = m[4:0]; c_rdy = rdy; end
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        applyStimulus(0, 8'h00, 8'h00, 1'b1);
        applyStimulus(1, 8'h00, 8'h00, 1'b1);
        applyStimulus(2, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_a_valid", 32'(a_valid), 32'd0);
        checkOutput("rst_a_idx",   32'(a_idx),   32'd0);
        checkOutput("rst_a_multi", 32'(a_multi), 32'd0);
        checkOutput("rst_a_pend",  32'(a_pend),  32'd0);
        checkOutput("rst_b_valid", 32'(b_valid), 32'd0);
        checkOutput("rst_c_valid", 32'(c_valid), 32'd0);
        checkOutput("rst_c_pend",  32'(c_pend),  32'd0);
        rst = 1'b0;

        $display("[TB] fixed priority, req=A0 pulse");
        applyStimulus(0, 8'hA0, 8'h00, 1'b1);
        @(negedge clk);
        applyStimulus(0, 8'h00, 8'h00, 1'b1);
        checkOutput("t1_pend",   32'(a_pend),  32'hA0);
        checkOutput("t1_valid",  32'(a_valid), 32'd0);
        @(negedge clk);
        checkOutput("t2_valid",  32'(a_valid), 32'd1);
        checkOutput("t2_idx",    32'(a_idx),   32'd7);
        checkOutput("t2_multi",  32'(a_multi), 32'd1);
        @(negedge clk);
        checkOutput("t3_valid",  32'(a_valid), 32'd1);
        checkOutput("t3_idx",    32'(a_idx),   32'd5);
        checkOutput("t3_multi",  32'(a_multi), 32'd0);
        checkOutput("t3_pend",   32'(a_pend),  32'h20);
        @(negedge clk);
        checkOutput("t4_valid",  32'(a_valid), 32'd0);
        checkOutput("t4_pend",   32'(a_pend),  32'h00);

        $display("[TB] back-pressure holds index 3 against later index 7");
        applyStimulus(0, 8'h08, 8'h00, 1'b0);
        @(negedge clk);
        applyStimulus(0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("bp_valid0", 32'(a_valid), 32'd1);
        checkOutput("bp_idx0",   32'(a_idx),   32'd3);
        applyStimulus(0, 8'h80, 8'h00, 1'b0);
        @(negedge clk);
        applyStimulus(0, 8'h00, 8'h00, 1'b0);
        checkOutput("bp_idx1",   32'(a_idx),   32'd3);
        checkOutput("bp_pend",   32'(a_pend),  32'h88);
        @(negedge clk);
        checkOutput("bp_idx2",   32'(a_idx),   32'd3);
        @(negedge clk);
        checkOutput("bp_valid3", 32'(a_valid), 32'd1);
        checkOutput("bp_idx3",   32'(a_idx),   32'd3);
        applyStimulus(0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("bp_valid4", 32'(a_valid), 32'd1);
        checkOutput("bp_idx4",   32'(a_idx),   32'd7);
        checkOutput("bp_multi4", 32'(a_multi), 32'd0);
        @(negedge clk);
        checkOutput("bp_valid5", 32'(a_valid), 32'd0);
        checkOutput("bp_pend5",  32'(a_pend),  32'h00);

        $display("[TB] masking and set-wins");
        applyStimulus(0, 8'h08, 8'h08, 1'b1);
        @(negedge clk);
        applyStimulus(0, 8'h00, 8'h08, 1'b1);
        checkOutput("mk_pend",   32'(a_pend),  32'h08);
        checkOutput("mk_valid0", 32'(a_valid), 32'd0);
        @(negedge clk);
        checkOutput("mk_valid1", 32'(a_valid), 32'd0);
        @(negedge clk);
        checkOutput("mk_valid2", 32'(a_valid), 32'd0);
        applyStimulus(0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("mk_valid3", 32'(a_valid), 32'd1);
        checkOutput("mk_idx3",   32'(a_idx),   32'd3);
        applyStimulus(0, 8'h08, 8'h00, 1'b1);
        @(negedge clk);
        applyStimulus(0, 8'h00, 8'h00, 1'b1);
        checkOutput("sw_pend",   32'(a_pend),  32'h08);
        @(negedge clk);
        checkOutput("sw_valid",  32'(a_valid), 32'd1);
        checkOutput("sw_idx",    32'(a_idx),   32'd3);
        @(negedge clk);
        checkOutput("sw_done",   32'(a_valid), 32'd0);
        checkOutput("sw_pend0",  32'(a_pend),  32'h00);

        $display("[TB] round-robin N=8, req=FF pulse");
        applyStimulus(1, 8'hFF, 8'h00, 1'b1);
        @(negedge clk);
        applyStimulus(1, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("rr8_multi_first", 32'(b_multi), 32'd1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("rr8_valid", 32'(b_valid), 32'd1);
            checkOutput("rr8_idx",   32'(b_idx),   32'(k));
            if (k == 7) checkOutput("rr8_multi_last", 32'(b_multi), 32'd0);
            @(negedge clk);
        end
        checkOutput("rr8_done",  32'(b_valid), 32'd0);
        checkOutput("rr8_pend",  32'(b_pend),  32'h00);

        $display("[TB] round-robin N=5 wrap");
        applyStimulus(2, 8'h10, 8'h00, 1'b1);
        @(negedge clk);
        applyStimulus(2, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("rr5_first_idx",  32'(c_idx),   32'd4);
        checkOutput("rr5_first_val",  32'(c_valid), 32'd1);
        @(negedge clk);
        checkOutput("rr5_gap",        32'(c_valid), 32'd0);
        applyStimulus(2, 8'h11, 8'h00, 1'b1);
        @(negedge clk);
        applyStimulus(2, 8'h00, 8'h00, 1'b1);
        checkOutput("rr5_pend",       32'(c_pend),  32'h11);
        @(negedge clk);
        checkOutput("rr5_idx0",       32'(c_idx),   32'd0);
        checkOutput("rr5_multi0",     32'(c_multi), 32'd1);
        checkOutput("rr5_range0",     32'(c_idx < 3'd5), 32'd1);
        @(negedge clk);
        checkOutput("rr5_idx1",       32'(c_idx),   32'd4);
        checkOutput("rr5_multi1",     32'(c_multi), 32'd0);
        checkOutput("rr5_range1",     32'(c_idx < 3'd5), 32'd1);
        @(negedge clk);
        checkOutput("rr5_done",       32'(c_valid), 32'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(0, 8'h30, 8'h00, 1'b0);
        @(negedge clk);
        applyStimulus(0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("mr_valid_pre", 32'(a_valid), 32'd1);
        checkOutput("mr_idx_pre",   32'(a_idx),   32'd5);
        checkOutput("mr_pend_pre",  32'(a_pend),  32'h30);
        rst = 1'b1;
        applyStimulus(0, 8'h01, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 8'h00, 8'h00, 1'b0);
        checkOutput("mr_valid",  32'(a_valid), 32'd0);
        checkOutput("mr_idx",    32'(a_idx),   32'd0);
        checkOutput("mr_multi",  32'(a_multi), 32'd0);
        checkOutput("mr_pend",   32'(a_pend),  32'h00);
        @(negedge clk);
        checkOutput("mr_pend_after",  32'(a_pend),  32'h00);
        checkOutput("mr_valid_after", 32'(a_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
